rsa_modexp_core: RTL and testbench

- Parametrised RSA modular-exponentiation engine. Computes o_result = i_a^i_e mod i_n using right-to-left binary exponentiation over radix-2 Montgomery multiplication.
- Successor to the fixed 256-bit decrypt core. Adds parametrised operand and exponent width, an explicit ready/valid handshake, an abort input, and an optional early-exit mode.
- Sits between the host-side wrapper (serial/Avalon bridge) and the operand registers.

---
 rtl/rsa_pkg.sv | 44 ++++
 rtl/rsa_mont_mul.sv | 117 +++++++++++
 rtl/rsa_modexp_core.sv | 200 ++++++++++++++++++++
 tb/tb_rsa_modexp_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation engine:
// FSM state encoding, latency helper and the radix-2 Montgomery step.
package rsa_pkg;

  // Widest operand the shared step helper is sized for; narrower
  // instances zero-extend into it and truncate the result back.
  localparam int RSA_MAX_W = 4096;

  typedef logic [RSA_MAX_W+1:0] rsa_acc_t;
  typedef logic [2:0]           rsa_state_t;

  localparam rsa_state_t ST_IDLE   = 3'd0;
  localparam rsa_state_t ST_PREP   = 3'd1;
  localparam rsa_state_t ST_MONT   = 3'd2;
  localparam rsa_state_t ST_UPDATE = 3'd3;
  localparam rsa_state_t ST_DONE   = 3'd4;

  // Cycles from the cycle i_start is sampled to the o_valid cycle
  // when all exp_width iterations run.
  function automatic int rsa_latency(input int width, input int exp_width);
    return 1 + width + exp_width * (width + 1);
  endfunction

  // One radix-2 Montgomery step: add b if the multiplier bit is set,
  // add n if the sum is odd (making it even), then halve.
  function automatic rsa_acc_t mont_step(input rsa_acc_t acc,
                                         input logic     a_bit,
                                         input rsa_acc_t b,
                                         input rsa_acc_t n);
    rsa_acc_t sum;
    if (a_bit) begin
      sum = acc + b;
    end else begin
      sum = acc;
    end
    if (sum[0]) begin
      sum = sum + n;
    end else begin
      sum = sum;
    end
    return {1'b0, sum[RSA_MAX_W+1:1]};
  endfunction

endpackage

// File: rtl/rsa_mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: o_data = a*b*2^-WIDTH mod n.
// The first step is taken on the i_start cycle, so o_done pulses exactly
// WIDTH cycles after i_start, together with the registered o_data.
module rsa_mont_mul
  import rsa_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_data,
  output logic             o_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH+1:0] acc_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] n_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [WIDTH-1:0] data_r;
  logic             done_r;

  logic [WIDTH+1:0] acc_sel_s;
  logic             bit_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic [WIDTH-1:0] n_sel_s;
  logic [WIDTH+1:0] step_s;
  logic [WIDTH+1:0] fin_s;
  logic             last_s;

  // Operand select: fresh inputs on start, latched copies while running.
  always_comb begin
    acc_sel_s = '0;
    bit_sel_s = 1'b0;
    b_sel_s   = '0;
    n_sel_s   = '0;
    if (i_start) begin
      acc_sel_s = '0;
      bit_sel_s = i_a[0];
      b_sel_s   = i_b;
      n_sel_s   = i_n;
    end else begin
      acc_sel_s = acc_r;
      bit_sel_s = a_sh_r[0];
      b_sel_s   = b_r;
      n_sel_s   = n_r;
    end
  end

  // Step datapath plus the single conditional final subtraction.
  always_comb begin
    step_s = (WIDTH+2)'(mont_step(rsa_acc_t'(acc_sel_s), bit_sel_s,
                                  rsa_acc_t'(b_sel_s), rsa_acc_t'(n_sel_s)));
    if (step_s >= {2'b00, n_sel_s}) begin
      fin_s = step_s - {2'b00, n_sel_s};
    end else begin
      fin_s = step_s;
    end
    last_s = (cnt_r == CNT_W'(WIDTH - 1));
  end

  // Multiplier sequencing: load-and-step on start, then WIDTH-1 more steps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_r  <= '0;
      a_sh_r <= '0;
      b_r    <= '0;
      n_r    <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      data_r <= '0;
      done_r <= 1'b0;
    end else if (i_clear) begin
      acc_r  <= '0;
      a_sh_r <= '0;
      b_r    <= '0;
      n_r    <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      data_r <= '0;
      done_r <= 1'b0;
    end else if (i_start) begin
      acc_r  <= step_s;
      a_sh_r <= {1'b0, i_a[WIDTH-1:1]};
      b_r    <= i_b;
      n_r    <= i_n;
      cnt_r  <= CNT_W'(1);
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      acc_r  <= step_s;
      a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
      cnt_r  <= cnt_r + CNT_W'(1);
      if (last_s) begin
        busy_r <= 1'b0;
        data_r <= WIDTH'(fin_s);
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign o_data = data_r;
  assign o_done = done_r;

endmodule

// File: rtl/rsa_modexp_core.sv
// RSA modular exponentiation o_result = i_a^i_e mod i_n, right-to-left
// binary method over two parallel Montgomery multipliers.
// m stays in the normal domain (mont(m, t) with t = a^(2^i)*R mod n),
// so no conversion out of the Montgomery domain is needed at the end.
// Optional macro RSA_EARLY_EXIT_EN: stop once the remaining exponent is
// zero (variable latency); undefined gives constant EXP_WIDTH iterations.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = WIDTH,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [EXP_WIDTH-1:0] i_e,
  input  logic [WIDTH-1:0]     i_n,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_result
);

  localparam int ITER_W = $clog2(EXP_WIDTH + 1);

  rsa_state_t           state_r;
  rsa_state_t           next_s;
  logic [WIDTH-1:0]     m_r;
  logic [WIDTH-1:0]     t_r;
  logic [WIDTH-1:0]     n_r;
  logic [EXP_WIDTH-1:0] e_r;
  logic [CNT_W-1:0]     cyc_r;
  logic [ITER_W-1:0]    iter_r;
  logic                 ready_r;
  logic                 valid_r;
  logic [WIDTH-1:0]     result_r;

  logic                 busy_s;
  logic                 abort_s;
  logic                 cyc_last_s;
  logic [WIDTH:0]       dbl_s;
  logic [WIDTH-1:0]     t_dbl_s;
  logic [EXP_WIDTH-1:0] e_next_s;
  logic [ITER_W-1:0]    iter_next_s;
  logic                 finish_s;
  logic [WIDTH-1:0]     m_upd_s;
  logic [WIDTH-1:0]     t_upd_s;

  logic                 mul_start_s;
  logic                 mul_clear_s;
  logic [WIDTH-1:0]     mm_data_s;
  logic                 mm_done_s;
  logic [WIDTH-1:0]     tt_data_s;
  logic                 tt_done_s;

  // Datapath helpers: modular doubling, exponent shift, update values.
  always_comb begin
    busy_s      = (state_r != ST_IDLE);
    abort_s     = i_abort && busy_s;
    cyc_last_s  = (cyc_r == CNT_W'(WIDTH - 1));
    dbl_s       = {t_r, 1'b0};
    if (dbl_s >= {1'b0, n_r}) begin
      t_dbl_s = WIDTH'(dbl_s - {1'b0, n_r});
    end else begin
      t_dbl_s = dbl_s[WIDTH-1:0];
    end
    e_next_s    = {1'b0, e_r[EXP_WIDTH-1:1]};
    iter_next_s = iter_r + ITER_W'(1);
`ifdef RSA_EARLY_EXIT_EN
    finish_s    = (e_next_s == {EXP_WIDTH{1'b0}});
`else
    finish_s    = (iter_next_s == ITER_W'(EXP_WIDTH));
`endif
    if (e_r[0] && mm_done_s) begin
      m_upd_s = mm_data_s;
    end else begin
      m_upd_s = m_r;
    end
    if (tt_done_s) begin
      t_upd_s = tt_data_s;
    end else begin
      t_upd_s = t_r;
    end
    mul_start_s = (state_r == ST_MONT) && (cyc_r == {CNT_W{1'b0}});
    mul_clear_s = abort_s;
  end

  // Next-state logic; abort from any busy state wins.
  always_comb begin
    next_s = ST_IDLE;
    if (abort_s) begin
      next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   next_s = i_start ? ST_PREP : ST_IDLE;
        ST_PREP:   next_s = cyc_last_s ? ST_MONT : ST_PREP;
        ST_MONT:   next_s = cyc_last_s ? ST_UPDATE : ST_MONT;
        ST_UPDATE: next_s = finish_s ? ST_DONE : ST_MONT;
        ST_DONE:   next_s = ST_IDLE;
        default:   next_s = ST_IDLE;
      endcase
    end
  end

  // State, operand registers and registered handshake outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      m_r      <= '0;
      t_r      <= '0;
      n_r      <= '0;
      e_r      <= '0;
      cyc_r    <= '0;
      iter_r   <= '0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      result_r <= '0;
    end else begin
      state_r <= next_s;
      ready_r <= (next_s == ST_IDLE);
      if (abort_s) begin
        cyc_r   <= '0;
        valid_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            valid_r <= 1'b0;
            if (i_start) begin
              m_r    <= {{(WIDTH-1){1'b0}}, 1'b1};
              t_r    <= i_a;
              e_r    <= i_e;
              n_r    <= i_n;
              iter_r <= '0;
              cyc_r  <= '0;
            end else begin
              cyc_r  <= '0;
            end
          end
          ST_PREP: begin
            t_r   <= t_dbl_s;
            cyc_r <= cyc_last_s ? {CNT_W{1'b0}} : cyc_r + CNT_W'(1);
          end
          ST_MONT: begin
            cyc_r <= cyc_last_s ? {CNT_W{1'b0}} : cyc_r + CNT_W'(1);
          end
          ST_UPDATE: begin
            m_r    <= m_upd_s;
            t_r    <= t_upd_s;
            e_r    <= e_next_s;
            iter_r <= iter_next_s;
            if (finish_s) begin
              result_r <= m_upd_s;
              valid_r  <= 1'b1;
            end else begin
              valid_r  <= 1'b0;
            end
          end
          ST_DONE: begin
            valid_r <= 1'b0;
          end
          default: begin
            valid_r <= 1'b0;
            cyc_r   <= '0;
          end
        endcase
      end
    end
  end

  rsa_mont_mul #(.WIDTH(WIDTH)) u_mul_mt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mul_start_s),
    .i_clear (mul_clear_s),
    .i_a     (m_r),
    .i_b     (t_r),
    .i_n     (n_r),
    .o_data  (mm_data_s),
    .o_done  (mm_done_s)
  );

  rsa_mont_mul #(.WIDTH(WIDTH)) u_mul_tt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mul_start_s),
    .i_clear (mul_clear_s),
    .i_a     (t_r),
    .i_b     (t_r),
    .i_n     (n_r),
    .o_data  (tt_data_s),
    .o_done  (tt_done_s)
  );

  assign o_ready  = ready_r;
  assign o_valid  = valid_r;
  assign o_result = result_r;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Scoreboard bench for rsa_modexp_core at WIDTH = EXP_WIDTH = 8.
// Expected result and o_valid cycle are pushed when a job is started and
// checked by a negedge monitor when o_valid appears.
module tb_rsa_modexp_core;

  localparam int W  = 8;
  localparam int EW = 8;

  typedef struct {
    int res;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  a;
  logic [EW-1:0] e;
  logic [W-1:0]  n;
  logic          ready;
  logic          valid;
  logic [W-1:0]  result;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t mon_item;
  int   last_res = 0;

  rsa_modexp_core #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_abort  (abort),
    .i_a      (a),
    .i_e      (e),
    .i_n      (n),
    .o_ready  (ready),
    .o_valid  (valid),
    .o_result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int modpow(input int ba, input int ex, input int md);
    longint r, b;
    int x;
    r = 1;
    b = ba % md;
    x = ex;
    while (x > 0) begin
      if (x[0]) r = (r * b) % md;
      b = (b * b) % md;
      x = x >> 1;
    end
    return int'(r % md);
  endfunction

  function automatic int exp_lat(input int ex);
    int k;
`ifdef RSA_EARLY_EXIT_EN
    k = 1;
    for (int i = 0; i < EW; i++) begin
      if (ex[i]) k = i + 1;
    end
`else
    k = EW;
`endif
    return 1 + W + k * (W + 1);
  endfunction

  // Monitor: every o_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_item = sb_q.pop_front();
        check("result", result, mon_item.res);
        check("latency", cyc, mon_item.cyc);
      end
    end
  end

  task automatic start_job(input int ja, input int je, input int jn,
                           input bit push, output int t0);
    exp_t it;
    @(posedge clk);
    #1;
    a     = W'(ja);
    e     = EW'(je);
    n     = W'(jn);
    start = 1'b1;
    t0    = cyc;
    if (push) begin
      it.res   = modpow(ja, je, jn);
      it.cyc   = t0 + exp_lat(je);
      last_res = it.res;
      sb_q.push_back(it);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    int t0;
    int ra, re, rn;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a     = '0;
    e     = '0;
    n     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_result", result, 0);
    rst = 1'b0;

    // Basic job with ready-window checks.
    start_job(88, 7, 187, 1'b1, t0);
    check("ready_busy_c1", ready, 0);
    while (cyc < t0 + exp_lat(7)) begin
      @(posedge clk);
      #1;
    end
    check("ready_last_busy", ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_done", ready, 1);
    wait_drain(20);

    // Directed and boundary operands.
    start_job(11, 23, 187, 1'b1, t0); wait_drain(200);
    start_job(88, 0, 187, 1'b1, t0);  wait_drain(200);
    start_job(88, 1, 187, 1'b1, t0);  wait_drain(200);
    start_job(11, 1, 187, 1'b1, t0);  wait_drain(200);
    start_job(0, 5, 187, 1'b1, t0);   wait_drain(200);
    start_job(254, 255, 255, 1'b1, t0); wait_drain(200);
    for (int i = 0; i < 6; i++) begin
      rn = $urandom_range(1, 127) * 2 + 1;
      ra = $urandom_range(0, rn - 1);
      re = $urandom_range(0, 255);
      start_job(ra, re, rn, 1'b1, t0);
      wait_drain(200);
    end

    // Second start while busy is ignored.
    start_job(88, 7, 187, 1'b1, t0);
    repeat (38) @(posedge clk);
    #1;
    a = 8'd5; e = 8'd3; n = 8'd13; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(200);

    // Abort at cycle 40: back to IDLE at 41, result untouched, no o_valid.
    start_job(11, 23, 187, 1'b0, t0);
    repeat (39) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_cycle", cyc, t0 + 41);
    check("abort_ready", ready, 1);
    check("abort_valid", valid, 0);
    check("abort_result", result, last_res);
    repeat (100) @(posedge clk);
    #1;
    check("abort_result_held", result, last_res);

    // Abort together with start in IDLE: start is accepted.
    abort = 1'b1;
    start_job(11, 23, 187, 1'b1, t0);
    abort = 1'b0;
    wait_drain(200);

    // Reset mid-operation at cycle 50.
    start_job(88, 7, 187, 1'b0, t0);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_result", result, 0);
    check("midrst_valid", valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start_job(88, 7, 187, 1'b1, t0);
    wait_drain(200);
    repeat (100) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
